// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction fields, opcodes, Tuse/Tnew
// constants and the decoded-hazard record used by the hazard controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [1:0] TUSE_0 = 2'd0;
  localparam logic [1:0] TUSE_1 = 2'd1;
  localparam logic [1:0] TUSE_2 = 2'd2;
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef struct packed {
    logic       use_rs;
    logic       use_rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] a3;
    logic       rwe;
    logic [1:0] tnew;
    logic       md_start;
    logic       md_div;
    logic       md_use;
  } dec_t;

  function automatic logic [5:0] Op(input logic [31:0] ir);
    return ir[31:26];
  endfunction
  function automatic logic [4:0] Rs(input logic [31:0] ir);
    return ir[25:21];
  endfunction
  function automatic logic [4:0] Rt(input logic [31:0] ir);
    return ir[20:16];
  endfunction
  function automatic logic [4:0] Rd(input logic [31:0] ir);
    return ir[15:11];
  endfunction
  function automatic logic [5:0] Func(input logic [31:0] ir);
    return ir[5:0];
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage instruction in, stall plus per-stage destination info out.
interface hazard_ctrl_if;
  logic [31:0] IR_D;
  logic        stall;
  logic [4:0]  A3_E, A3_M, A3_W;
  logic        RWE_E, RWE_M, RWE_W;
  logic [1:0]  Tnew_E, Tnew_M;
  logic        md_busy;

  modport master (
    input  IR_D,
    output stall, A3_E, A3_M, A3_W, RWE_E, RWE_M, RWE_W, Tnew_E, Tnew_M, md_busy
  );
  modport slave (
    output IR_D,
    input  stall, A3_E, A3_M, A3_W, RWE_E, RWE_M, RWE_W, Tnew_E, Tnew_M, md_busy
  );
endinterface

// File: rtl/hz_decode.sv
// Combinational decode of the D-stage instruction into operand use times,
// destination/result timing and multiply/divide unit interaction.
module hz_decode
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic unused_shamt;
  assign unused_shamt = ^ir[10:6];

  always_comb begin
    dec = '0;
    case (Op(ir))
      OP_RTYPE: begin
        case (Func(ir))
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: begin
            dec.use_rs = 1'b1; dec.tuse_rs = TUSE_1;
            dec.use_rt = 1'b1; dec.tuse_rt = TUSE_1;
            dec.a3 = Rd(ir); dec.rwe = 1'b1; dec.tnew = TNEW_1;
          end
          FN_SLL: begin
            dec.use_rt = 1'b1; dec.tuse_rt = TUSE_1;
            dec.a3 = Rd(ir); dec.rwe = 1'b1; dec.tnew = TNEW_1;
          end
          FN_JR: begin
            dec.use_rs = 1'b1; dec.tuse_rs = TUSE_0;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            dec.use_rs = 1'b1; dec.tuse_rs = TUSE_1;
            dec.use_rt = 1'b1; dec.tuse_rt = TUSE_1;
            dec.md_start = 1'b1; dec.md_use = 1'b1;
            dec.md_div = (Func(ir) == FN_DIV) || (Func(ir) == FN_DIVU);
          end
          FN_MFHI, FN_MFLO: begin
            dec.a3 = Rd(ir); dec.rwe = 1'b1; dec.tnew = TNEW_1;
            dec.md_use = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            dec.use_rs = 1'b1; dec.tuse_rs = TUSE_1;
            dec.md_use = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_ADDIU: begin
        dec.use_rs = 1'b1; dec.tuse_rs = TUSE_1;
        dec.a3 = Rt(ir); dec.rwe = 1'b1; dec.tnew = TNEW_1;
      end
      OP_LUI: begin
        dec.a3 = Rt(ir); dec.rwe = 1'b1; dec.tnew = TNEW_1;
      end
      OP_LW: begin
        dec.use_rs = 1'b1; dec.tuse_rs = TUSE_1;
        dec.a3 = Rt(ir); dec.rwe = 1'b1; dec.tnew = TNEW_2;
      end
      OP_SW: begin
        dec.use_rs = 1'b1; dec.tuse_rs = TUSE_1;
        dec.use_rt = 1'b1; dec.tuse_rt = TUSE_2;
      end
      OP_BEQ: begin
        dec.use_rs = 1'b1; dec.tuse_rs = TUSE_0;
        dec.use_rt = 1'b1; dec.tuse_rt = TUSE_0;
      end
      OP_JAL: begin
        dec.a3 = 5'd31; dec.rwe = 1'b1; dec.tnew = TNEW_0;
      end
      default: ;
    endcase
    // $0 is hardwired; a write there must never look like a producer.
    if (dec.a3 == 5'd0) dec.rwe = 1'b0;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: E/M/W destination pipeline, multiply/divide busy
// counter and the D-stage stall decision.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.master hz
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  dec_t             dec;
  logic [4:0]       rs, rt;
  logic             rs_stall, rt_stall, md_stall;
  logic             start_E, div_E;
  logic [CNT_W-1:0] md_cnt;

  hz_decode u_decode (
    .ir  (hz.IR_D),
    .dec (dec)
  );

  assign rs = Rs(hz.IR_D);
  assign rt = Rt(hz.IR_D);

  always_comb begin
    rs_stall = dec.use_rs && (rs != 5'd0) &&
               (((rs == hz.A3_E) && hz.RWE_E && (hz.Tnew_E > dec.tuse_rs)) ||
                ((rs == hz.A3_M) && hz.RWE_M && (hz.Tnew_M > dec.tuse_rs)));
    rt_stall = dec.use_rt && (rt != 5'd0) &&
               (((rt == hz.A3_E) && hz.RWE_E && (hz.Tnew_E > dec.tuse_rt)) ||
                ((rt == hz.A3_M) && hz.RWE_M && (hz.Tnew_M > dec.tuse_rt)));
  end

  assign hz.md_busy = start_E || (md_cnt != '0);
  assign md_stall   = dec.md_use && hz.md_busy;
  assign hz.stall   = rs_stall || rt_stall || md_stall;

  // D -> E (bubble on stall), E -> M, M -> W
  always_ff @(posedge clk) begin
    if (reset) begin
      hz.A3_E   <= '0;
      hz.RWE_E  <= 1'b0;
      hz.Tnew_E <= '0;
      hz.A3_M   <= '0;
      hz.RWE_M  <= 1'b0;
      hz.Tnew_M <= '0;
      hz.A3_W   <= '0;
      hz.RWE_W  <= 1'b0;
    end else begin
      hz.A3_E   <= hz.stall ? 5'd0 : dec.a3;
      hz.RWE_E  <= hz.stall ? 1'b0 : dec.rwe;
      hz.Tnew_E <= hz.stall ? 2'd0 : dec.tnew;
      hz.A3_M   <= hz.A3_E;
      hz.RWE_M  <= hz.RWE_E;
      hz.Tnew_M <= (hz.Tnew_E == 2'd0) ? 2'd0 : hz.Tnew_E - 2'd1;
      hz.A3_W   <= hz.A3_M;
      hz.RWE_W  <= hz.RWE_M;
    end
  end

  // MD unit occupancy: the stall on md_use keeps a reload from hitting a nonzero count
  always_ff @(posedge clk) begin
    if (reset) begin
      start_E <= 1'b0;
      div_E   <= 1'b0;
      md_cnt  <= '0;
    end else begin
      start_E <= dec.md_start && !hz.stall;
      div_E   <= dec.md_div && !hz.stall;
      if (start_E)
        md_cnt <= div_E ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, MD busy and reset cases.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP = 32'h0;

  initial begin
    reset   = 1'b1;
    hz.IR_D = NOP;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_stall", 32'(hz.stall), 0);
    chk("rst_a3e", 32'(hz.A3_E), 0);
    chk("rst_rwee", 32'(hz.RWE_E), 0);
    chk("rst_tnewe", 32'(hz.Tnew_E), 0);
    chk("rst_a3m", 32'(hz.A3_M), 0);
    chk("rst_tnewm", 32'(hz.Tnew_M), 0);
    chk("rst_a3w", 32'(hz.A3_W), 0);
    chk("rst_rwew", 32'(hz.RWE_W), 0);
    chk("rst_mdbusy", 32'(hz.md_busy), 0);
    cyc();
    chk("nop_stall", 32'(hz.stall), 0);
    chk("nop_a3e", 32'(hz.A3_E), 0);

    // lw $8 then addu $9,$8,$8: one stall
    hz.IR_D = itype(6'h23, 0, 8, 0);
    #1 chk("lw_nostall", 32'(hz.stall), 0);
    cyc();
    hz.IR_D = rtype(8, 8, 9, 6'h21);
    #1;
    chk("lu_stall1", 32'(hz.stall), 1);
    chk("lu_a3e", 32'(hz.A3_E), 8);
    chk("lu_tnewe", 32'(hz.Tnew_E), 2);
    cyc();
    chk("lu_stall2", 32'(hz.stall), 0);
    chk("lu_tnewm", 32'(hz.Tnew_M), 1);
    chk("lu_a3m", 32'(hz.A3_M), 8);
    chk("lu_bubble", 32'(hz.A3_E), 0);
    cyc();
    hz.IR_D = NOP;
    chk("lu_a3e_addu", 32'(hz.A3_E), 9);
    chk("lu_rwee_addu", 32'(hz.RWE_E), 1);
    chk("lu_a3w", 32'(hz.A3_W), 8);
    cyc();
    cyc();

    // addiu $5 then beq $5,$0: one stall
    hz.IR_D = itype(6'h09, 0, 5, 1);
    cyc();
    hz.IR_D = itype(6'h04, 5, 0, 0);
    #1 chk("ab_stall1", 32'(hz.stall), 1);
    cyc();
    chk("ab_stall2", 32'(hz.stall), 0);
    cyc();

    // lw $5 then beq $5,$0: two stalls
    hz.IR_D = itype(6'h23, 0, 5, 0);
    cyc();
    hz.IR_D = itype(6'h04, 5, 0, 0);
    #1 chk("lb_stall1", 32'(hz.stall), 1);
    cyc();
    chk("lb_stall2", 32'(hz.stall), 1);
    cyc();
    chk("lb_stall3", 32'(hz.stall), 0);
    cyc();
    hz.IR_D = NOP;
    cyc();
    cyc();

    // lw $7 then sw $7,0($0): store data used late, no stall
    hz.IR_D = itype(6'h23, 0, 7, 0);
    cyc();
    hz.IR_D = itype(6'h2b, 0, 7, 0);
    #1 chk("ls_nostall", 32'(hz.stall), 0);
    cyc();

    // jal: writes $31 with result ready at E
    hz.IR_D = {6'h03, 26'h10};
    cyc();
    hz.IR_D = NOP;
    chk("jal_a3e", 32'(hz.A3_E), 31);
    chk("jal_tnewe", 32'(hz.Tnew_E), 0);
    chk("jal_rwee", 32'(hz.RWE_E), 1);
    cyc();
    cyc();

    // mult then mflo: six stall cycles
    hz.IR_D = rtype(1, 2, 0, 6'h18);
    #1 chk("mult_nostall", 32'(hz.stall), 0);
    cyc();
    hz.IR_D = rtype(0, 0, 3, 6'h12);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("md_stall%0d", i), 32'(hz.stall), 1);
      chk($sformatf("md_busy%0d", i), 32'(hz.md_busy), 1);
      cyc();
    end
    #1;
    chk("md_release", 32'(hz.stall), 0);
    chk("md_idle", 32'(hz.md_busy), 0);
    cyc();
    hz.IR_D = NOP;
    chk("mflo_a3e", 32'(hz.A3_E), 3);
    chk("mflo_rwee", 32'(hz.RWE_E), 1);
    chk("mflo_tnewe", 32'(hz.Tnew_E), 1);
    cyc();

    // div, then reset mid-operation
    hz.IR_D = rtype(1, 2, 0, 6'h1a);
    cyc();
    hz.IR_D = NOP;
    cyc();
    cyc();
    cyc();
    chk("div_busy", 32'(hz.md_busy), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("div_rst_busy", 32'(hz.md_busy), 0);
    hz.IR_D = rtype(0, 0, 4, 6'h12);
    #1 chk("div_rst_mflo", 32'(hz.stall), 0);
    cyc();
    chk("div_rst_a3e", 32'(hz.A3_E), 4);

    // write to $0 is never a producer
    hz.IR_D = rtype(1, 2, 0, 6'h21);
    cyc();
    hz.IR_D = rtype(0, 0, 3, 6'h21);
    #1;
    chk("z_rwee", 32'(hz.RWE_E), 0);
    chk("z_a3e", 32'(hz.A3_E), 0);
    chk("z_stall", 32'(hz.stall), 0);
    cyc();
    hz.IR_D = NOP;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
